sc_spil_txseq: RTL and testbench
================================

SC_SPIL_TXSEQ -- requirements
Module: sc_spil_txseq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: DEPTH, default 8, TX word FIFO depth; power of two, 2..16.
REQ-003 Ports:
- SYSCLK  in  1  system clock; all logic on rising edge.
- SYSRST  in  1  asynchronous active-high reset.
- PUSH  in  1  write PUSH_DATA into FIFO this cycle.
- PUSH_DATA  in  32  TX word.
- GO  in  1  one-cycle request to drain the FIFO to the SPI engine.
- FLUSH  in  1  discard FIFO contents, clear OVERFLOW.
- SPIBUSY  in  1  engine busy.
- SPICOMPLETE  in  1  engine one-cycle end-of-word pulse.
- TXDATA  out  32  word presented to engine.
- TXSTART  out  1  one-cycle engine start pulse.
- CSEXTEND  out  1  keep CS asserted after current word.
- FULL  out  1  FIFO count == DEPTH.
- EMPTY  out  1  FIFO count == 0.
- LEVEL  out  $clog2(DEPTH)+1  FIFO count.
- OVERFLOW  out  1  sticky: push dropped while full.
- ACTIVE  out  1  state != IDLE.
- DONE  out  1  one-cycle pulse: drain finished.

Function
REQ-004 FSM states SHALL be IDLE, WAIT, CHECK; all outputs registered; FULL/EMPTY/LEVEL derived from the count register.
REQ-005 IDLE: on GO=1, EMPTY=0, SPIBUSY=0 -> next edge TXSTART=1, TXDATA=FIFO head, head popped, CSEXTEND=(LEVEL>1), state WAIT.
REQ-006 IDLE: GO with EMPTY=1 or SPIBUSY=1 SHALL be ignored (no pulse, no state change, no DONE).
REQ-007 GO in WAIT or CHECK SHALL be ignored.
REQ-008 TXSTART SHALL be high exactly one cycle per issued word; TXDATA and CSEXTEND SHALL hold until the next issue.
REQ-009 WAIT: on SPICOMPLETE=1 -> CHECK; otherwise stay in WAIT, with no timeout.
REQ-010 CHECK: EMPTY=0 and SPIBUSY=0 -> issue as REQ-005 (same pop and CSEXTEND rule), state WAIT.
REQ-011 CHECK: EMPTY=0 and SPIBUSY=1 -> stay in CHECK.
REQ-012 CHECK: EMPTY=1 -> IDLE, DONE=1 for one cycle, CSEXTEND=0.
REQ-013 Issue latency SHALL be one cycle from GO sampled, and one cycle from entry to CHECK when the issue conditions hold.
REQ-014 Push rule: a push SHALL be accepted if FULL=0, or if a pop occurs in the same cycle.
- An accepted push writes the tail and LEVEL updates next edge (+1; or +0 with simultaneous pop).
REQ-015 A push when FULL=1 with no pop SHALL be dropped and OVERFLOW set to 1; OVERFLOW holds until FLUSH or reset.
REQ-016 Pointers SHALL wrap modulo DEPTH; LEVEL SHALL never exceed DEPTH nor go below 0.
REQ-017 Pushes during WAIT/CHECK SHALL be accepted and drained in the same sequence.
- CSEXTEND is evaluated at each issue only; a word pushed after an issue with CSEXTEND=0 starts a new CS frame.
REQ-018 FLUSH SHALL zero pointers, LEVEL and OVERFLOW on the next edge; FLUSH wins over a simultaneous PUSH, which is dropped.
REQ-019 FLUSH in WAIT SHALL leave the in-flight word unaffected and force CSEXTEND=0; CHECK then finds EMPTY and returns to IDLE with DONE.
REQ-020 FLUSH in IDLE coincident with GO SHALL suppress the issue.

Reset
REQ-021 SYSRST=1 SHALL immediately, without a clock, force:
- state IDLE;
- pointers and LEVEL 0, EMPTY=1, FULL=0;
- TXDATA=0, TXSTART=0, CSEXTEND=0, OVERFLOW=0, ACTIVE=0, DONE=0.
REQ-022 Reset mid-transfer SHALL discard all FIFO contents; no TXSTART SHALL occur until a new GO after reset release.
REQ-023 FIFO storage contents need not be reset.

Verification
REQ-024 Push 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003; GO; complete each word 5 cycles after TXSTART.
- Expect 3 TXSTART pulses in order with CSEXTEND 1, 1, 0.
- Expect DONE one cycle after the CHECK that follows the third SPICOMPLETE; LEVEL returns to 0.
REQ-025 DEPTH=8: push 9 words -> FULL=1 after the 8th, 9th dropped, OVERFLOW=1, LEVEL=8; FLUSH -> LEVEL=0, OVERFLOW=0, EMPTY=1.
REQ-026 Full FIFO, GO: push in the issue cycle -> push accepted, LEVEL stays 8.
REQ-027 Hold SPIBUSY=1 in CHECK for 4 cycles with 1 word queued -> no TXSTART until the cycle after SPIBUSY falls.
REQ-028 Assert SYSRST in WAIT with 2 words queued -> outputs at reset values asynchronously; after release, SPICOMPLETE and GO with EMPTY=1 produce no TXSTART and no DONE.
REQ-029 FLUSH during WAIT with 3 words queued -> CSEXTEND=0 next edge; after SPICOMPLETE, DONE pulses and no further TXSTART.

Source files
------------

// File: rtl/sc_spil_txseq_if.sv
// Bundle of the TX sequencer's host-side and SPI-engine-side signals.
// master: the host/engine side that drives requests and engine status.
// slave:  the sequencer itself.
interface sc_spil_txseq_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          PUSH;
  logic [31:0]   PUSH_DATA;
  logic          GO;
  logic          FLUSH;
  logic          SPIBUSY;
  logic          SPICOMPLETE;
  logic [31:0]   TXDATA;
  logic          TXSTART;
  logic          CSEXTEND;
  logic          FULL;
  logic          EMPTY;
  logic [LW-1:0] LEVEL;
  logic          OVERFLOW;
  logic          ACTIVE;
  logic          DONE;

  modport master (
    output PUSH, PUSH_DATA, GO, FLUSH, SPIBUSY, SPICOMPLETE,
    input  TXDATA, TXSTART, CSEXTEND, FULL, EMPTY, LEVEL, OVERFLOW, ACTIVE, DONE
  );

  modport slave (
    input  PUSH, PUSH_DATA, GO, FLUSH, SPIBUSY, SPICOMPLETE,
    output TXDATA, TXSTART, CSEXTEND, FULL, EMPTY, LEVEL, OVERFLOW, ACTIVE, DONE
  );
endinterface

// File: rtl/sc_spil_txseq.sv
// SPI TX word sequencer: a small word FIFO drained one word at a time into
// the SPI engine, keeping CS asserted while more words are queued.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing in flight; waits for GO with data queued and engine free
// WAIT  | a word was handed to the engine; waits for its SPICOMPLETE
// CHECK | word finished; issue the next one, or finish with DONE if empty
module sc_spil_txseq #(
  parameter int DEPTH = 8
) (
  input logic           SYSCLK,
  input logic           SYSRST,
  sc_spil_txseq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_CNT  = LW'(1);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [LW-1:0] cnt;
  logic [31:0]   txdata;
  logic          txstart;
  logic          csextend;
  logic          overflow;
  logic          active;
  logic          done;

  logic empty;
  logic full;
  logic issue_ok;
  logic pop;
  logic push_ok;
  logic push_drop;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

  // FLUSH blocks an issue so the flushed head is never sent.
  assign issue_ok  = !empty && !bus.SPIBUSY && !bus.FLUSH;
  assign pop       = issue_ok && (((state == IDLE) && bus.GO) || (state == CHECK));
  assign push_ok   = bus.PUSH && !bus.FLUSH && (!full || pop);
  assign push_drop = bus.PUSH && !bus.FLUSH && full && !pop;

  // Word storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge SYSCLK) begin
    if (push_ok) mem[wr_ptr] <= bus.PUSH_DATA;
  end

  // Sequencer FSM, FIFO pointers/count and all registered outputs.
  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      txdata   <= '0;
      txstart  <= 1'b0;
      csextend <= 1'b0;
      overflow <= 1'b0;
      active   <= 1'b0;
      done     <= 1'b0;
    end else begin
      txstart <= 1'b0;
      done    <= 1'b0;

      if (bus.FLUSH) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        cnt      <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop)      cnt <= cnt + 1'b1;
        else if (!push_ok && pop) cnt <= cnt - 1'b1;
        if (push_drop) overflow <= 1'b1;
      end

      // CS extension is decided from the level seen at issue time only.
      if (pop) begin
        txstart  <= 1'b1;
        txdata   <= mem[rd_ptr];
        csextend <= (cnt > ONE_CNT);
      end else if (bus.FLUSH) begin
        csextend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state  <= WAIT;
            active <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.SPICOMPLETE) state <= CHECK;
        end
        CHECK: begin
          if (pop) begin
            state <= WAIT;
          end else if (empty) begin
            state    <= IDLE;
            active   <= 1'b0;
            done     <= 1'b1;
            csextend <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TXDATA   = txdata;
  assign bus.TXSTART  = txstart;
  assign bus.CSEXTEND = csextend;
  assign bus.FULL     = full;
  assign bus.EMPTY    = empty;
  assign bus.LEVEL    = cnt;
  assign bus.OVERFLOW = overflow;
  assign bus.ACTIVE   = active;
  assign bus.DONE     = done;
endmodule

// File: tb/tb_sc_spil_txseq.sv
// Bench for sc_spil_txseq: directed scenarios plus randomized traffic, with
// a queue-based reference model and a negedge monitor/scoreboard.
module tb_sc_spil_txseq;
  localparam int DEPTH = 8;
  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_CHECK = 2;

  typedef struct {
    logic [31:0] d;
    logic        cs;
  } exp_t;

  logic SYSCLK;
  logic SYSRST;

  sc_spil_txseq_if #(.DEPTH(DEPTH)) bus ();

  sc_spil_txseq #(.DEPTH(DEPTH)) dut (
    .SYSCLK (SYSCLK),
    .SYSRST (SYSRST),
    .bus    (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 0;

  // reference model state
  logic [31:0] mq[$];
  exp_t        exp_q[$];
  int          m_phase;
  bit          m_ovf, m_cs, m_txstart, m_done;

  // engine emulation / stimulus helpers
  int eng_cnt = 0;
  int lat     = 5;
  bit xbusy   = 0;
  bit xcmp    = 0;

  initial begin
    SYSCLK = 0;
    forever #5 SYSCLK = ~SYSCLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_phase = PH_IDLE;
    m_ovf = 0; m_cs = 0; m_txstart = 0; m_done = 0;
    eng_cnt = 0;
  endtask

  // One clock edge of the sequencer's intended behaviour, from the inputs
  // sampled at that edge.
  task automatic model_step();
    int lvl;
    bit issue;
    exp_t e;
    lvl = mq.size();
    m_txstart = 0;
    m_done = 0;
    issue = !bus.FLUSH && (lvl > 0) && !bus.SPIBUSY &&
            (((m_phase == PH_IDLE) && bus.GO) || (m_phase == PH_CHECK));
    if (issue) begin
      e.d  = mq.pop_front();
      e.cs = (lvl > 1);
      exp_q.push_back(e);
      m_cs = (lvl > 1);
      m_txstart = 1;
    end else if (bus.FLUSH) begin
      m_cs = 0;
    end
    if (bus.FLUSH) begin
      mq.delete();
      m_ovf = 0;
    end else if (bus.PUSH) begin
      if (lvl < DEPTH || issue) mq.push_back(bus.PUSH_DATA);
      else m_ovf = 1;
    end
    if (m_phase == PH_IDLE) begin
      if (issue) m_phase = PH_WAIT;
    end else if (m_phase == PH_WAIT) begin
      if (bus.SPICOMPLETE) m_phase = PH_CHECK;
    end else begin
      if (issue) m_phase = PH_WAIT;
      else if (lvl == 0) begin
        m_phase = PH_IDLE;
        m_done = 1;
        m_cs = 0;
      end
    end
  endtask

  // Drive one cycle: engine outputs, clock edge, model update, clear pulses.
  task automatic cycle();
    bus.SPICOMPLETE = xcmp;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) bus.SPICOMPLETE = 1;
    end
    bus.SPIBUSY = (eng_cnt > 0) || xbusy;
    @(posedge SYSCLK);
    if (SYSRST) model_reset();
    else model_step();
    #1;
    if (bus.TXSTART && !SYSRST) eng_cnt = lat;
    bus.PUSH = 0;
    bus.GO = 0;
    bus.FLUSH = 0;
    xcmp = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    bus.PUSH = 1;
    bus.PUSH_DATA = w;
    cycle();
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((bus.ACTIVE || eng_cnt != 0) && k < budget) begin
      cycle();
      k++;
    end
    chk("drain_timeout_active", {31'b0, bus.ACTIVE}, 32'd0);
  endtask

  // Scoreboard/monitor: compares every cycle away from the rising edge.
  always @(negedge SYSCLK) begin
    if (mon_on) begin
      if (bus.TXSTART) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL txstart_unexpected: got data %0h want no issue at %0t", bus.TXDATA, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("issue_txdata", bus.TXDATA, e.d);
          chk("issue_csextend", {31'b0, bus.CSEXTEND}, {31'b0, e.cs});
        end
      end
      chk("txstart", {31'b0, bus.TXSTART}, {31'b0, m_txstart});
      chk("done", {31'b0, bus.DONE}, {31'b0, m_done});
      chk("csextend", {31'b0, bus.CSEXTEND}, {31'b0, m_cs});
      chk("level", {28'b0, bus.LEVEL}, mq.size());
      chk("full", {31'b0, bus.FULL}, {31'b0, mq.size() == DEPTH});
      chk("empty", {31'b0, bus.EMPTY}, {31'b0, mq.size() == 0});
      chk("overflow", {31'b0, bus.OVERFLOW}, {31'b0, m_ovf});
      chk("active", {31'b0, bus.ACTIVE}, {31'b0, m_phase != PH_IDLE});
    end
  end

  initial begin
    int ts;
    int k;
    int ppush;
    bus.PUSH = 0; bus.PUSH_DATA = 0; bus.GO = 0; bus.FLUSH = 0;
    bus.SPIBUSY = 0; bus.SPICOMPLETE = 0;
    SYSRST = 1;
    model_reset();
    mon_on = 1;
    repeat (3) cycle();
    chk("reset_level", {28'b0, bus.LEVEL}, 32'd0);
    chk("reset_empty", {31'b0, bus.EMPTY}, 32'd1);
    SYSRST = 0;
    cycle();

    // three-word burst, engine completes 5 cycles after each start
    lat = 5;
    push_word(32'hA5A5_0001);
    push_word(32'hA5A5_0002);
    push_word(32'hA5A5_0003);
    bus.GO = 1;
    cycle();
    chk("burst_first_start", {31'b0, bus.TXSTART}, 32'd1);
    chk("burst_first_data", bus.TXDATA, 32'hA5A5_0001);
    wait_idle(200);
    chk("burst_level_end", {28'b0, bus.LEVEL}, 32'd0);

    // fill to full, overflow on the ninth word, then flush
    for (int i = 0; i < 8; i++) push_word(32'h1000_0000 + i);
    chk("fill_full", {31'b0, bus.FULL}, 32'd1);
    push_word(32'hDEAD_0009);
    chk("fill_overflow", {31'b0, bus.OVERFLOW}, 32'd1);
    chk("fill_level", {28'b0, bus.LEVEL}, 32'd8);
    bus.FLUSH = 1;
    bus.PUSH = 1;
    bus.PUSH_DATA = 32'hBAD0_BAD0;
    cycle();
    chk("flush_level", {28'b0, bus.LEVEL}, 32'd0);
    chk("flush_overflow", {31'b0, bus.OVERFLOW}, 32'd0);
    chk("flush_empty", {31'b0, bus.EMPTY}, 32'd1);

    // full FIFO, GO with a push in the issue cycle
    for (int i = 0; i < 8; i++) push_word(32'h2000_0000 + i);
    bus.GO = 1;
    bus.PUSH = 1;
    bus.PUSH_DATA = 32'h2000_00FF;
    cycle();
    chk("full_go_push_level", {28'b0, bus.LEVEL}, 32'd8);
    chk("full_go_push_ovf", {31'b0, bus.OVERFLOW}, 32'd0);
    lat = 2;
    wait_idle(400);

    // engine held busy through CHECK with one word left
    lat = 5;
    push_word(32'h3000_0001);
    push_word(32'h3000_0002);
    bus.GO = 1;
    cycle();
    k = 0;
    while (eng_cnt != 1 && k < 20) begin cycle(); k++; end
    xbusy = 1;
    ts = 0;
    repeat (5) begin
      cycle();
      if (bus.TXSTART) ts++;
    end
    chk("busy_hold_no_start", ts, 32'd0);
    xbusy = 0;
    cycle();
    chk("start_after_busy", {31'b0, bus.TXSTART}, 32'd1);
    chk("start_after_busy_data", bus.TXDATA, 32'h3000_0002);
    wait_idle(200);

    // reset asserted while waiting with two words queued
    push_word(32'h4000_0001);
    push_word(32'h4000_0002);
    push_word(32'h4000_0003);
    bus.GO = 1;
    cycle();
    cycle();
    #1;
    SYSRST = 1;
    model_reset();
    #1;
    chk("rst_txstart", {31'b0, bus.TXSTART}, 32'd0);
    chk("rst_txdata", bus.TXDATA, 32'd0);
    chk("rst_level", {28'b0, bus.LEVEL}, 32'd0);
    chk("rst_active", {31'b0, bus.ACTIVE}, 32'd0);
    chk("rst_csextend", {31'b0, bus.CSEXTEND}, 32'd0);
    chk("rst_full", {31'b0, bus.FULL}, 32'd0);
    cycle();
    SYSRST = 0;
    xcmp = 1;
    cycle();
    bus.GO = 1;
    cycle();
    chk("post_rst_no_start", {31'b0, bus.TXSTART}, 32'd0);
    chk("post_rst_no_done", {31'b0, bus.DONE}, 32'd0);
    cycle();

    // flush while waiting with three words queued
    lat = 5;
    for (int i = 0; i < 4; i++) push_word(32'h5000_0000 + i);
    bus.GO = 1;
    cycle();
    cycle();
    bus.FLUSH = 1;
    cycle();
    chk("flush_wait_cs", {31'b0, bus.CSEXTEND}, 32'd0);
    chk("flush_wait_level", {28'b0, bus.LEVEL}, 32'd0);
    wait_idle(200);

    // randomized traffic
    ppush = 30;
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 0) ppush = (ppush == 30) ? 85 : 30;
      lat = $urandom_range(1, 6);
      bus.PUSH = ($urandom_range(0, 99) < ppush);
      bus.PUSH_DATA = $urandom;
      bus.GO = ($urandom_range(0, 99) < 12);
      bus.FLUSH = ($urandom_range(0, 99) < 3);
      xbusy = ($urandom_range(0, 99) < 15);
      cycle();
    end
    xbusy = 0;
    wait_idle(500);
    cycle();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    mon_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
